// File: rtl/hazard_stall_controller.sv
// Pipeline interlock controller: load-use stalls, branch flushes and the
// start/hold/writeback sequencing of the multi-cycle multdiv unit.
module hazard_stall_controller #(
    parameter int MD_TIMEOUT = 40
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] fd_rs1,
    input  logic [4:0] fd_rs2,
    input  logic       fd_uses_rs1,
    input  logic       fd_uses_rs2,
    input  logic [4:0] dx_rd,
    input  logic       dx_is_load,
    input  logic       dx_is_mult,
    input  logic       dx_is_div,
    input  logic       x_branch_taken,
    input  logic       md_result_rdy,
    input  logic       md_exception,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_x,
    output logic       bubble_x,
    output logic       flush_d,
    output logic       flush_x,
    output logic       ctrl_mult,
    output logic       ctrl_div,
    output logic       md_busy,
    output logic       md_wb_en,
    output logic       md_wb_exc,
    output logic [4:0] md_wb_rd,
    output logic       md_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'(MD_TIMEOUT - 1);

    state_t     state_r, state_next_s;
    logic [5:0] cnt_r, cnt_next_s;
    logic       exc_r, exc_next_s;
    logic [4:0] wb_rd_r, wb_rd_next_s;
    logic       timeout_r, timeout_next_s;
    logic       start_s;
    logic       load_use_s;

    assign start_s    = dx_is_mult | dx_is_div;
    assign load_use_s = dx_is_load && (dx_rd != 5'd0) &&
                        ((fd_uses_rs1 && (fd_rs1 == dx_rd)) ||
                         (fd_uses_rs2 && (fd_rs2 == dx_rd)));

    // State and datapath registers, cleared by the synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 6'd0;
            exc_r     <= 1'b0;
            wb_rd_r   <= 5'd0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            exc_r     <= exc_next_s;
            wb_rd_r   <= wb_rd_next_s;
            timeout_r <= timeout_next_s;
        end
    end

    // Next-state logic for the multdiv sequencer.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        exc_next_s     = exc_r;
        wb_rd_next_s   = wb_rd_r;
        timeout_next_s = timeout_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s = ST_BUSY;
                    cnt_next_s   = 6'd0;
                    exc_next_s   = 1'b0;
                    wb_rd_next_s = dx_rd;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_next_s = cnt_r + 6'd1;
                if (md_result_rdy) begin
                    exc_next_s   = md_exception;
                    state_next_s = ST_WB;
                end else if (cnt_r == CNT_LAST) begin
                    // Result never arrived: abort with an exception writeback.
                    exc_next_s     = 1'b1;
                    timeout_next_s = 1'b1;
                    state_next_s   = ST_WB;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_WB:   state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Pipeline controls; the multdiv start outranks branch flush and load-use.
    always_comb begin
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_x    = 1'b0;
        bubble_x   = 1'b0;
        flush_d    = 1'b0;
        flush_x    = 1'b0;
        ctrl_mult  = 1'b0;
        ctrl_div   = 1'b0;
        md_busy    = 1'b0;
        md_wb_en   = 1'b0;
        md_wb_exc  = 1'b0;
        md_wb_rd   = 5'd0;
        md_timeout = 1'b0;
        if (reset) begin
            md_busy    = (state_r != ST_IDLE);
            md_wb_rd   = wb_rd_r;
            md_timeout = timeout_r;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        ctrl_mult = dx_is_mult;
                        ctrl_div  = dx_is_div & ~dx_is_mult;
                        stall_f   = 1'b1;
                        stall_d   = 1'b1;
                        stall_x   = 1'b1;
                        bubble_x  = 1'b1;
                    end else if (x_branch_taken) begin
                        flush_d = 1'b1;
                        flush_x = 1'b1;
                    end else if (load_use_s) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_x = 1'b1;
                    end else begin
                        stall_f = 1'b0;
                    end
                end
                ST_BUSY: begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    stall_x  = 1'b1;
                    bubble_x = 1'b1;
                end
                ST_WB: begin
                    md_wb_en  = 1'b1;
                    md_wb_exc = exc_r;
                end
                default: md_busy = 1'b0;
            endcase
        end else begin
            md_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared every cycle against a cycle-count based reference model.
module tb_hazard_stall_controller;

    localparam int T = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] fd_rs1, fd_rs2, dx_rd;
    logic       fd_uses_rs1, fd_uses_rs2, dx_is_load, dx_is_mult, dx_is_div;
    logic       x_branch_taken, md_result_rdy, md_exception;
    logic       stall_f, stall_d, stall_x, bubble_x, flush_d, flush_x;
    logic       ctrl_mult, ctrl_div, md_busy, md_wb_en, md_wb_exc, md_timeout;
    logic [4:0] md_wb_rd;

    int checks = 0;
    int errors = 0;

    // Reference model: an op in flight is tracked by cycles elapsed since its pulse.
    bit         m_active;
    int         m_elapsed;
    bit         m_wb;
    bit         m_exc;
    logic [4:0] m_rd;
    bit         m_to;

    hazard_stall_controller #(.MD_TIMEOUT(T)) dut (
        .clock(clock), .reset(reset),
        .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
        .fd_uses_rs1(fd_uses_rs1), .fd_uses_rs2(fd_uses_rs2),
        .dx_rd(dx_rd), .dx_is_load(dx_is_load),
        .dx_is_mult(dx_is_mult), .dx_is_div(dx_is_div),
        .x_branch_taken(x_branch_taken),
        .md_result_rdy(md_result_rdy), .md_exception(md_exception),
        .stall_f(stall_f), .stall_d(stall_d), .stall_x(stall_x),
        .bubble_x(bubble_x), .flush_d(flush_d), .flush_x(flush_x),
        .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .md_busy(md_busy), .md_wb_en(md_wb_en), .md_wb_exc(md_wb_exc),
        .md_wb_rd(md_wb_rd), .md_timeout(md_timeout)
    );

    always #5 clock = ~clock;

    // Order: sf sd sx bx fd fx mul div busy wben wbexc tmo rd[4:0]
    function automatic logic [16:0] expected();
        logic sf, sd, sx, bx, fd, fx, cm, cd, bz, we, wx;
        bit lu;
        {sf, sd, sx, bx, fd, fx, cm, cd, bz, we, wx} = 11'd0;
        if (!reset) return 17'd0;
        lu = dx_is_load && dx_rd != 5'd0 &&
             ((fd_uses_rs1 && fd_rs1 == dx_rd) || (fd_uses_rs2 && fd_rs2 == dx_rd));
        if (m_wb) begin
            bz = 1'b1; we = 1'b1; wx = m_exc;
        end else if (m_active) begin
            bz = 1'b1; {sf, sd, sx, bx} = 4'b1111;
        end else if (dx_is_mult || dx_is_div) begin
            {sf, sd, sx, bx} = 4'b1111;
            cm = dx_is_mult; cd = dx_is_div && !dx_is_mult;
        end else if (x_branch_taken) begin
            fd = 1'b1; fx = 1'b1;
        end else if (lu) begin
            sf = 1'b1; sd = 1'b1; fx = 1'b1;
        end
        return {sf, sd, sx, bx, fd, fx, cm, cd, bz, we, wx, m_to, m_rd};
    endfunction

    task automatic model_update(input bit rst, input bit op, input bit rdy,
                                input bit exc, input logic [4:0] rd);
        if (!rst) begin
            m_active = 0; m_elapsed = 0; m_wb = 0; m_exc = 0; m_rd = 5'd0; m_to = 0;
        end else if (m_wb) begin
            m_wb = 0;
        end else if (m_active) begin
            if (rdy) begin
                m_exc = exc; m_wb = 1; m_active = 0;
            end else if (m_elapsed == T) begin
                m_exc = 1; m_to = 1; m_wb = 1; m_active = 0;
            end else begin
                m_elapsed++;
            end
        end else if (op) begin
            m_active = 1; m_elapsed = 1; m_rd = rd;
        end
    endtask

    // Compare all outputs mid-cycle, then advance one clock and the model.
    task automatic tick(input string tag);
        logic [16:0] obs, exp;
        bit r, op, rdy, exc;
        logic [4:0] rd;
        #1;
        obs = {stall_f, stall_d, stall_x, bubble_x, flush_d, flush_x, ctrl_mult,
               ctrl_div, md_busy, md_wb_en, md_wb_exc, md_timeout, md_wb_rd};
        exp = expected();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        r = reset; op = dx_is_mult | dx_is_div; rdy = md_result_rdy;
        exc = md_exception; rd = dx_rd;
        @(posedge clock);
        model_update(r, op, rdy, exc, rd);
        #1;
    endtask

    task automatic clear_inputs();
        fd_rs1 = 5'd0; fd_rs2 = 5'd0; fd_uses_rs1 = 1'b0; fd_uses_rs2 = 1'b0;
        dx_rd = 5'd0; dx_is_load = 1'b0; dx_is_mult = 1'b0; dx_is_div = 1'b0;
        x_branch_taken = 1'b0; md_result_rdy = 1'b0; md_exception = 1'b0;
    endtask

    initial begin
        m_active = 0; m_elapsed = 0; m_wb = 0; m_exc = 0; m_rd = 5'd0; m_to = 0;
        clear_inputs();
        reset = 1'b0;
        // Reset with busy-looking inputs: everything must read 0.
        dx_is_mult = 1'b1; dx_rd = 5'd9; x_branch_taken = 1'b1;
        tick("reset_a");
        tick("reset_b");
        clear_inputs();
        reset = 1'b1;
        tick("idle");

        // Load-use on rs1, then the load moves to M.
        dx_is_load = 1'b1; dx_rd = 5'd5; fd_rs1 = 5'd5; fd_uses_rs1 = 1'b1; fd_rs2 = 5'd7;
        fd_uses_rs2 = 1'b1;
        tick("load_use");
        clear_inputs();
        tick("load_use_clear");
        dx_is_load = 1'b1; dx_rd = 5'd0; fd_rs1 = 5'd0; fd_uses_rs1 = 1'b1;
        tick("load_use_r0");
        clear_inputs();
        dx_is_load = 1'b1; dx_rd = 5'd6; fd_rs2 = 5'd6; fd_uses_rs2 = 1'b0;
        tick("load_use_unused");

        // mul $3, result at cycle 4.
        clear_inputs();
        for (int i = 0; i <= 7; i++) begin
            dx_is_mult = (i <= 5); dx_rd = 5'd3; md_result_rdy = (i == 4);
            tick($sformatf("mul_c%0d", i));
        end
        // div $4, result with exception at cycle 2.
        clear_inputs();
        for (int i = 0; i <= 4; i++) begin
            dx_is_div = (i <= 3); dx_rd = 5'd4;
            md_result_rdy = (i == 2); md_exception = (i == 2);
            tick($sformatf("div_c%0d", i));
        end
        // Timeout: no result ever.
        clear_inputs();
        for (int i = 0; i <= 12; i++) begin
            dx_is_mult = (i <= 9); dx_rd = 5'd11;
            tick($sformatf("tmo_c%0d", i));
        end

        // Branch overrides load-use; branch ignored while busy.
        clear_inputs();
        dx_is_load = 1'b1; dx_rd = 5'd5; fd_rs1 = 5'd5; fd_uses_rs1 = 1'b1; x_branch_taken = 1'b1;
        tick("branch_over_lu");
        clear_inputs();
        dx_is_mult = 1'b1; dx_rd = 5'd2;
        tick("mul_for_br");
        x_branch_taken = 1'b1; dx_is_load = 1'b1; fd_rs1 = 5'd2; fd_uses_rs1 = 1'b1;
        tick("br_busy_1");
        tick("br_busy_2");
        md_result_rdy = 1'b1;
        tick("br_busy_rdy");
        md_result_rdy = 1'b0;
        tick("br_wb");

        // Reset in BUSY cycle 3, then a fresh mul.
        clear_inputs();
        for (int i = 0; i <= 3; i++) begin
            dx_is_mult = 1'b1; dx_rd = 5'd7;
            reset = (i != 3);
            tick($sformatf("rst_busy_c%0d", i));
        end
        reset = 1'b1;
        tick("after_rst");
        dx_rd = 5'd8;
        tick("fresh_pulse");
        clear_inputs();
        tick("fresh_busy");

        // Random traffic; a branch never coincides with a mul/div start.
        for (int i = 0; i < 600; i++) begin
            int md;
            reset = ($urandom_range(0, 49) != 0);
            md = $urandom_range(0, 5);
            dx_is_mult = (md == 1); dx_is_div = (md == 2);
            x_branch_taken = (md > 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            dx_is_load = $urandom_range(0, 1);
            dx_rd = 5'($urandom_range(0, 3));
            fd_rs1 = 5'($urandom_range(0, 3)); fd_rs2 = 5'($urandom_range(0, 3));
            fd_uses_rs1 = $urandom_range(0, 1); fd_uses_rs2 = $urandom_range(0, 1);
            md_result_rdy = ($urandom_range(0, 4) == 0);
            md_exception = $urandom_range(0, 1);
            tick($sformatf("rand_%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline interlock and sequencing controller for the 5-stage CPU. Consumes the register-operand fields produced by the D-stage instruction parsers, such as rs1/rs2, plus X-stage status. It generates stall, bubble and flush controls for the F/D/X latches. It also sequences the multi-cycle multdiv unit: it issues one start pulse, holds the pipeline until the result is ready or a timeout fires, then releases the instruction with a one-cycle writeback qualifier.

## Interface
- MD_TIMEOUT, 40, max cycles spent in BUSY before a forced abort; legal range 2..63; counter width 6 bits.
- clock  in  1  single pipeline clock, rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clock.
- fd_rs1  in  5  source register 1 of the instruction in F/D.
- fd_rs2  in  5  source register 2 of the instruction in F/D (rs2 parser output).
- fd_uses_rs1, fd_uses_rs2  in  1 each  the F/D instruction actually reads that operand.
- dx_rd  in  5  destination register of the instruction in D/X.
- dx_is_load  in  1  D/X instruction is a load word.
- dx_is_mult, dx_is_div  in  1 each  D/X instruction is mul or div; mutually exclusive.
- x_branch_taken  in  1  X stage redirects the PC (taken branch, j, jal, jr, bex).
- md_result_rdy  in  1  multdiv result valid this cycle.
- md_exception  in  1  multdiv overflow or divide-by-zero; qualified by md_result_rdy.
- stall_f, stall_d, stall_x  out  1 each  hold the PC, F/D latch and D/X latch respectively.
- bubble_x  out  1  write a nop into X/M instead of the X result.
- flush_d, flush_x  out  1 each  write a nop into the F/D and D/X latches respectively.
- ctrl_mult, ctrl_div  out  1 each  one-cycle multdiv start pulses.
- md_busy  out  1  FSM is not IDLE.
- md_wb_en  out  1  X result mux selects the multdiv result this cycle.
- md_wb_exc  out  1  the multdiv result carries an exception; write rstatus.
- md_wb_rd  out  5  destination latched at start.
- md_timeout  out  1  sticky; set when the timeout fires.

## Operation
- FSM states: IDLE, BUSY, WB. Reset sets state=IDLE, cnt=0, md_wb_rd=0 and md_timeout=0. While reset is low, every output is forced to 0.
- IDLE, with dx_is_mult or dx_is_div set:
  - Pulse ctrl_mult or ctrl_div (one only), latch md_wb_rd=dx_rd, clear cnt, go to BUSY.
  - In the same cycle assert stall_f, stall_d, stall_x and bubble_x.
- BUSY:
  - Assert stall_f, stall_d, stall_x and bubble_x; cnt increments each cycle.
  - If md_result_rdy is set, latch exc=md_exception and go to WB.
  - Otherwise, if cnt==MD_TIMEOUT-1, set md_timeout, set exc=1 and go to WB.
- WB (exactly one cycle):
  - md_wb_en=1 and md_wb_exc=exc; all stalls and bubbles are deasserted, so the mul/div leaves X.
  - Return to IDLE.
- Load-use hazard (combinational, IDLE only): the condition is dx_is_load && dx_rd!=0 && ((fd_uses_rs1 && fd_rs1==dx_rd) || (fd_uses_rs2 && fd_rs2==dx_rd)).
  - When it holds, assert stall_f, stall_d and flush_x for that cycle.
  - It clears naturally the next cycle, once the load has moved to M.
- Register $0 never produces a hazard.
- Branch flush (IDLE only): x_branch_taken asserts flush_d and flush_x.
  - It overrides the load-use stall: stall_f and stall_d are forced to 0, because the F/D instruction is on the wrong path.
- In BUSY and WB, x_branch_taken and the load-use condition are ignored.
- A mul/div entering IDLE with a simultaneous load-use condition is impossible (D/X holds a single instruction). If both flags read high anyway, the multdiv path wins.
- Back-to-back mul/div: the second one enters D/X at the end of WB and starts in the following IDLE cycle. It gets a fresh pulse and a fresh latch of md_wb_rd.
- If reset falls during BUSY, the FSM goes to IDLE next edge. No WB occurs and no pulse is reissued; md_timeout clears.

## Timing
- Start pulse: same cycle the op is first seen in IDLE. It is never repeated for the same instruction.
- Multdiv latency as seen by the pipeline:
  - Pulse at cycle 0, md_result_rdy at cycle N (N≥1), WB at N+1; the pipeline resumes at N+2.
  - Total stall is N+1 cycles.
- Timeout: the abort decision is taken in the BUSY cycle with cnt=MD_TIMEOUT-1, and WB follows.
  - md_timeout is registered: it rises the cycle after that decision and stays high until reset.
- A load-use stall lasts exactly 1 cycle. Flush signals are combinational from x_branch_taken, zero-cycle.
- md_busy is registered, from the state.

## Test plan
- lw $5 in D/X, F/D add $6,$5,$7 (rs1=5, uses_rs1=1) -> exactly one cycle of stall_f=stall_d=flush_x=1, then all 0. Repeat with dx_rd=0 -> no stall.
- mul $3 in D/X, md_result_rdy at cycle 4 -> ctrl_mult=1 only at cycle 0; stalls and bubble_x during cycles 0-4; cycle 5 md_wb_en=1, md_wb_rd=3, md_wb_exc=0; md_busy=0 at cycle 6.
- div $4 with md_result_rdy and md_exception at cycle 2 -> md_wb_exc=1 with md_wb_en at cycle 3; md_timeout stays 0.
- MD_TIMEOUT=8, md_result_rdy held at 0 -> WB at cycle 9 with md_wb_exc=1; md_timeout=1 from cycle 9 onward until reset.
- Load-use condition with x_branch_taken=1 in the same cycle -> flush_d=flush_x=1, stall_f=stall_d=0. During BUSY, x_branch_taken=1 -> no flush.
- reset low in BUSY cycle 3 -> next cycle IDLE, all outputs 0, no md_wb_en; a new mul after release gets a fresh start pulse.
